palette_lookup: RTL and testbench
=================================

Name: palette_lookup

Overview:
- Read-side client of the 256x16 palette RAM.
- Converts the compositor's 8-bit pixel index stream into 4:4:4 RGB through the RAM's registered read port (1-cycle latency).
- Also services CPU palette readback requests on the same read port, using only cycles not consumed by active pixel lookups.
- Sits between the layer compositor and the video output encoders.

Parameters:
- ADDR_W, 8, palette address width (entries = 2**ADDR_W).
- DATA_W, 16, palette word width. Colour field is [11:0]; [15:12] is ignored for colour.

Ports:
- clk_i  input  1  pixel/system clock
- rst_i  input  1  synchronous, active-high reset
- pix_valid_i  input  1  pixel slot present this cycle
- pix_blank_i  input  1  slot is in blanking (no lookup, output black)
- pix_index_i  input  ADDR_W  palette index for this slot
- pal_rd_en_o  output  1  palette RAM read enable (combinational)
- pal_rd_addr_o  output  ADDR_W  palette RAM read address (combinational)
- pal_rd_data_i  input  DATA_W  palette RAM read data, valid the cycle after the address
- rgb_valid_o  output  1  output pixel slot valid
- rgb_blank_o  output  1  output slot is blanking
- rgb_r_o  output  4  red
- rgb_g_o  output  4  green
- rgb_b_o  output  4  blue
- cpu_req_i  input  1  CPU readback request (single-cycle pulse)
- cpu_addr_i  input  ADDR_W  readback address, sampled with cpu_req_i
- cpu_busy_o  output  1  request in flight; new requests ignored
- cpu_ack_o  output  1  one-cycle pulse: cpu_data_o updated
- cpu_data_o  output  DATA_W  last readback word, held until next ack

Behaviour:
- Pixel lookup
  - Slot used = pix_valid_i & ~pix_blank_i.
  - When used: pal_rd_en_o=1, pal_rd_addr_o=pix_index_i.
- Pixel pipeline (2 stages, no stall)
  - Stage 1 registers valid and blank.
  - Stage 2 registers outputs: r=data[11:8], g=data[7:4], b=data[3:0].
  - Latency is exactly 2 cycles from pix_valid_i to rgb_valid_o.
  - Blank slot: rgb_valid_o=1, rgb_blank_o=1, rgb_*=0.
  - Invalid slot: rgb_valid_o=0, rgb_* hold previous values.
- CPU FSM states: IDLE, PEND, WAIT.
  - IDLE: cpu_req_i latches cpu_addr_i, next state PEND. cpu_busy_o=0.
  - PEND: if the pixel slot is unused this cycle, drive pal_rd_en_o=1 and pal_rd_addr_o=latched address, next state WAIT. Otherwise stay in PEND with no timeout. CPU waits for blanking or an idle slot. cpu_busy_o=1.
  - WAIT: at the clock edge ending this cycle, capture pal_rd_data_i into cpu_data_o and register cpu_ack_o=1, so the ack is high for one cycle after leaving WAIT. Next state IDLE. cpu_busy_o=1.
  - Minimum latency: request sampled at edge 1, ack high in cycle 3. A new request is accepted in the ack cycle.
  - cpu_req_i while cpu_busy_o=1 is ignored; no queueing.
- Priority
  - Pixel lookups always win the read port.
  - CPU issue and pixel lookup never share a cycle.
  - pal_rd_en_o=0 when neither is active; pal_rd_addr_o is then don't-care, but it is driven with the pending CPU address to avoid X.
- Wrap/width
  - Indices are used unmodified (no offset arithmetic).
  - All ADDR_W values are legal, including 0 and 2**ADDR_W-1.
- Reset
  - FSM goes to IDLE; pipeline valids clear.
  - Outputs reset to: rgb_valid_o=0, rgb_blank_o=0, rgb_*=0, cpu_ack_o=0, cpu_busy_o=0, cpu_data_o=0.
  - Reset mid-request drops the request; no ack is issued.
  - Pixels in flight are discarded.

Test Plan:
- Memory preloaded entry 0x12=0x0ABC. pix_valid_i=1 and pix_index_i=0x12 in cycle 0 -> rgb_valid_o=1, r=0xA, g=0xB, b=0xC in cycle 2; pal_rd_addr_o=0x12 in cycle 0.
- Continuous indices 0x00..0xFF, one per cycle -> 256 consecutive valid outputs in order, each matching memory[11:0]. Index 0xFF is followed by 0x00 without a bubble.
- Blank slot in the middle of the stream -> at +2 cycles: rgb_valid_o=1, rgb_blank_o=1, RGB=0. pal_rd_en_o=0 in the slot cycle.
- cpu_req_i with addr 0x40 (memory 0xF123) while idle, no pixels -> busy cycles 1-2, cpu_ack_o high only in cycle 3, cpu_data_o=0xF123 held afterwards.
- cpu_req_i during 10 active pixel cycles followed by blanking -> no CPU issue during active pixels (pixel outputs unaffected), CPU issue in the first blank cycle, ack 2 cycles later with correct data. A second cpu_req_i while busy is ignored: only one ack.
- rst_i asserted while FSM is in PEND, with pixels in flight -> no ack, rgb_valid_o=0 the cycle after reset, busy=0. A post-reset request completes normally.

Source files
------------

// File: rtl/palette_lookup_if.sv
// palette_lookup_if: bundles every non-clock/reset signal of palette_lookup.
//   Pixel in    : pix_valid_i, pix_blank_i, pix_index_i      (compositor -> lookup)
//   Palette RAM : pal_rd_en_o, pal_rd_addr_o, pal_rd_data_i  (registered read, 1-cycle latency)
//   RGB out     : rgb_valid_o, rgb_blank_o, rgb_r_o/g_o/b_o  (lookup -> encoders)
//   CPU readback: cpu_req_i, cpu_addr_i, cpu_busy_o, cpu_ack_o, cpu_data_o
// Suffixes are from the palette_lookup point of view. The slave modport is the
// palette_lookup side; the master modport is the environment side.
//
// Handshake semantics: pixels are a pure valid stream with no backpressure;
// one slot per cycle, and the output appears exactly two cycles later.
// cpu_req_i is a one-cycle pulse that is only accepted while cpu_busy_o is
// low; cpu_ack_o pulses for one cycle when cpu_data_o has been refreshed.
interface palette_lookup_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) ();
  logic              pix_valid_i;
  logic              pix_blank_i;
  logic [ADDR_W-1:0] pix_index_i;
  logic              pal_rd_en_o;
  logic [ADDR_W-1:0] pal_rd_addr_o;
  logic [DATA_W-1:0] pal_rd_data_i;
  logic              rgb_valid_o;
  logic              rgb_blank_o;
  logic [3:0]        rgb_r_o;
  logic [3:0]        rgb_g_o;
  logic [3:0]        rgb_b_o;
  logic              cpu_req_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic              cpu_busy_o;
  logic              cpu_ack_o;
  logic [DATA_W-1:0] cpu_data_o;

  modport slave (
    input  pix_valid_i, pix_blank_i, pix_index_i, pal_rd_data_i, cpu_req_i, cpu_addr_i,
    output pal_rd_en_o, pal_rd_addr_o, rgb_valid_o, rgb_blank_o, rgb_r_o, rgb_g_o,
           rgb_b_o, cpu_busy_o, cpu_ack_o, cpu_data_o
  );

  modport master (
    output pix_valid_i, pix_blank_i, pix_index_i, pal_rd_data_i, cpu_req_i, cpu_addr_i,
    input  pal_rd_en_o, pal_rd_addr_o, rgb_valid_o, rgb_blank_o, rgb_r_o, rgb_g_o,
           rgb_b_o, cpu_busy_o, cpu_ack_o, cpu_data_o
  );
endinterface

// File: rtl/palette_lookup.sv
// palette_lookup: read-side client of the palette RAM. Converts the 8-bit
// pixel index stream to 4:4:4 RGB (two-stage pipeline, no stall) and fits
// CPU palette readbacks into read-port cycles that pixels do not use.
// Ports:
//   clk_i       : pixel/system clock
//   rst_i       : synchronous, active-high reset
//   bus         : palette_lookup_if.slave (pixel in, RAM read port, RGB out, CPU readback)
//   cpu_state_o : debug view of the CPU readback FSM state
module palette_lookup #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  palette_lookup_if.slave     bus,
  output logic [1:0]          cpu_state_o
);

  typedef enum logic [1:0] {
    CPU_IDLE = 2'd0,
    CPU_PEND = 2'd1,
    CPU_WAIT = 2'd2
  } cpu_state_e;

  cpu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cpu_addr_q, cpu_addr_d;
  logic [DATA_W-1:0] cpu_data_q, cpu_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              cpu_issue;
  logic              pix_used;

  logic              s1_valid_q, s1_blank_q;
  logic              rgb_valid_q, rgb_blank_q;
  logic [11:0]       rgb_q;

  // A slot consumes the read port only when it is visible (not blanking).
  assign pix_used = bus.pix_valid_i & ~bus.pix_blank_i;

  // CPU FSM: next state and datapath.
  always_comb begin
    state_d    = state_q;
    cpu_addr_d = cpu_addr_q;
    cpu_data_d = cpu_data_q;
    cpu_ack_d  = 1'b0;
    cpu_issue  = 1'b0;
    case (state_q)
      CPU_IDLE: begin
        if (bus.cpu_req_i) begin
          cpu_addr_d = bus.cpu_addr_i;
          state_d    = CPU_PEND;
        end
      end
      CPU_PEND: begin
        // Pixels always win; the CPU waits indefinitely for a free slot.
        if (!pix_used) begin
          cpu_issue = 1'b1;
          state_d   = CPU_WAIT;
        end
      end
      CPU_WAIT: begin
        cpu_data_d = bus.pal_rd_data_i;
        cpu_ack_d  = 1'b1;
        state_d    = CPU_IDLE;
      end
      default: state_d = CPU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CPU_IDLE;
      cpu_addr_q <= '0;
      cpu_data_q <= '0;
      cpu_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cpu_addr_q <= cpu_addr_d;
      cpu_data_q <= cpu_data_d;
      cpu_ack_q  <= cpu_ack_d;
    end
  end

  // Read port: when idle the address still follows the latched CPU address
  // so the RAM never sees X.
  assign bus.pal_rd_en_o   = pix_used | cpu_issue;
  assign bus.pal_rd_addr_o = pix_used ? bus.pix_index_i : cpu_addr_q;

  // Pixel pipeline. Stage 1 tracks the slot while the RAM read is in
  // flight; stage 2 registers the colour. Invalid slots leave the colour
  // and blank flags untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_blank_q  <= 1'b0;
      rgb_valid_q <= 1'b0;
      rgb_blank_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      s1_valid_q  <= bus.pix_valid_i;
      s1_blank_q  <= bus.pix_blank_i;
      rgb_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rgb_blank_q <= s1_blank_q;
        rgb_q       <= s1_blank_q ? 12'h000 : bus.pal_rd_data_i[11:0];
      end
    end
  end

  assign bus.rgb_valid_o = rgb_valid_q;
  assign bus.rgb_blank_o = rgb_blank_q;
  assign bus.rgb_r_o     = rgb_q[11:8];
  assign bus.rgb_g_o     = rgb_q[7:4];
  assign bus.rgb_b_o     = rgb_q[3:0];
  assign bus.cpu_busy_o  = (state_q != CPU_IDLE);
  assign bus.cpu_ack_o   = cpu_ack_q;
  assign bus.cpu_data_o  = cpu_data_q;
  assign cpu_state_o     = state_q;

endmodule

// File: tb/tb_palette_lookup.sv
// tb_palette_lookup: directed bench for palette_lookup with a behavioural
// 256x16 palette RAM (registered read port) and an expected-output queue for
// the pixel stream.
module tb_palette_lookup;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  palette_lookup_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  palette_lookup #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .cpu_state_o (dbg_state)
  );

  // ---------------- palette RAM model ----------------
  logic [15:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = i[7:0];
      mem[i] = {~a[3:0], a ^ 8'h5A, a[3:0]};
    end
    mem[8'h12] = 16'h0ABC;
    mem[8'h40] = 16'hF123;
    mem[8'h41] = 16'h8E71;
  end

  always @(posedge clk) begin
    if (bus.pal_rd_en_o) bus.pal_rd_data_i <= mem[bus.pal_rd_addr_o];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [13:0] exp_q[$];   // {valid, blank, rgb[11:0]}
  logic        last_blank;
  logic [11:0] last_rgb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive all inputs just after the edge, record the
  // expected RGB for this slot, and compare the output for the slot driven
  // two cycles earlier.
  task automatic cycle(input logic v, input logic b, input logic [7:0] idx,
                       input logic req, input logic [7:0] caddr, input logic rst_v);
    logic [13:0] e;
    logic [13:0] got;
    @(posedge clk); #1;
    rst              = rst_v;
    bus.pix_valid_i  = v;
    bus.pix_blank_i  = b;
    bus.pix_index_i  = idx;
    bus.cpu_req_i    = req;
    bus.cpu_addr_i   = caddr;
    if (v && b)  e = {2'b11, 12'h000};
    else if (v)  e = {2'b10, mem[idx][11:0]};
    else         e = {1'b0, last_blank, last_rgb};
    last_blank = e[12];
    last_rgb   = e[11:0];
    exp_q.push_back(e);
    #1;
    if (exp_q.size() > 2) begin
      e   = exp_q.pop_front();
      got = {bus.rgb_valid_o, bus.rgb_blank_o, bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o};
      check("rgb_out", 32'(got), 32'(e));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  int ack_cnt;

  initial begin
    rst = 1'b1;
    bus.pix_valid_i = 1'b0;
    bus.pix_blank_i = 1'b0;
    bus.pix_index_i = '0;
    bus.cpu_req_i   = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.pal_rd_data_i = '0;
    last_blank = 1'b0;
    last_rgb   = '0;

    // Reset values.
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 32'(bus.rgb_valid_o), 32'h0);
    check("rst_blank", 32'(bus.rgb_blank_o), 32'h0);
    check("rst_rgb",   32'({bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o}), 32'h0);
    check("rst_ack",   32'(bus.cpu_ack_o), 32'h0);
    check("rst_busy",  32'(bus.cpu_busy_o), 32'h0);
    check("rst_data",  32'(bus.cpu_data_o), 32'h0);

    // Single lookup: index 0x12 -> 0x0ABC, RGB A/B/C two cycles later.
    cycle(1'b1, 1'b0, 8'h12, 1'b0, 8'h00, 1'b0);
    check("single_en",   32'(bus.pal_rd_en_o), 32'h1);
    check("single_addr", 32'(bus.pal_rd_addr_o), 32'h12);
    idle(1);
    check("single_v1",   32'(bus.rgb_valid_o), 32'h0);
    idle(1);
    check("single_valid", 32'(bus.rgb_valid_o), 32'h1);
    check("single_r", 32'(bus.rgb_r_o), 32'hA);
    check("single_g", 32'(bus.rgb_g_o), 32'hB);
    check("single_b", 32'(bus.rgb_b_o), 32'hC);
    idle(1);
    check("single_hold_v", 32'(bus.rgb_valid_o), 32'h0);
    check("single_hold_r", 32'(bus.rgb_r_o), 32'hA);

    // Full index sweep 0x00..0xFF, then wrap back to 0x00 without a bubble.
    for (int i = 0; i < 256; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0, 8'h00, 1'b0);
      check("sweep_addr", 32'(bus.pal_rd_addr_o), 32'(i));
    end
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Blank slot mid-stream.
    cycle(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b1, 8'h06, 1'b0, 8'h00, 1'b0);
    check("blank_rd_en", 32'(bus.pal_rd_en_o), 32'h0);
    cycle(1'b1, 1'b0, 8'h07, 1'b0, 8'h00, 1'b0);
    idle(1);
    check("blank_out", 32'({bus.rgb_valid_o, bus.rgb_blank_o, bus.rgb_r_o, bus.rgb_g_o, bus.rgb_b_o}),
          32'h3000);
    idle(3);

    // CPU readback while idle: addr 0x40 -> 0xF123, ack in cycle 3.
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
    check("cpu0_busy_c0", 32'(bus.cpu_busy_o), 32'h0);
    idle(1);
    check("cpu0_busy_c1", 32'(bus.cpu_busy_o), 32'h1);
    check("cpu0_ack_c1",  32'(bus.cpu_ack_o), 32'h0);
    check("cpu0_en_c1",   32'(bus.pal_rd_en_o), 32'h1);
    check("cpu0_addr_c1", 32'(bus.pal_rd_addr_o), 32'h40);
    idle(1);
    check("cpu0_busy_c2", 32'(bus.cpu_busy_o), 32'h1);
    check("cpu0_ack_c2",  32'(bus.cpu_ack_o), 32'h0);
    check("cpu0_en_c2",   32'(bus.pal_rd_en_o), 32'h0);
    idle(1);
    check("cpu0_ack_c3",  32'(bus.cpu_ack_o), 32'h1);
    check("cpu0_busy_c3", 32'(bus.cpu_busy_o), 32'h0);
    check("cpu0_data_c3", 32'(bus.cpu_data_o), 32'hF123);
    idle(1);
    check("cpu0_ack_c4",  32'(bus.cpu_ack_o), 32'h0);
    check("cpu0_data_c4", 32'(bus.cpu_data_o), 32'hF123);

    // CPU request during 10 active pixels, then blanking. A second request
    // while busy (addr 0x12) must be ignored.
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h30 + i), (i == 0 || i == 3), (i == 0) ? 8'h41 : 8'h12, 1'b0);
      check("cpu1_pix_addr", 32'(bus.pal_rd_addr_o), 32'(8'h30 + i));
      if (i > 0) check("cpu1_busy", 32'(bus.cpu_busy_o), 32'h1);
      if (bus.cpu_ack_o) ack_cnt++;
    end
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("cpu1_issue_en",   32'(bus.pal_rd_en_o), 32'h1);
    check("cpu1_issue_addr", 32'(bus.pal_rd_addr_o), 32'h41);
    if (bus.cpu_ack_o) ack_cnt++;
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("cpu1_ack_early", 32'(bus.cpu_ack_o), 32'h0);
    if (bus.cpu_ack_o) ack_cnt++;
    cycle(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
    check("cpu1_ack",  32'(bus.cpu_ack_o), 32'h1);
    check("cpu1_data", 32'(bus.cpu_data_o), 32'h8E71);
    if (bus.cpu_ack_o) ack_cnt++;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      if (bus.cpu_ack_o) ack_cnt++;
    end
    check("cpu1_ack_count", 32'(ack_cnt), 32'd1);
    check("cpu1_data_held", 32'(bus.cpu_data_o), 32'h8E71);

    // Reset while the request is pending behind active pixels.
    cycle(1'b1, 1'b0, 8'h50, 1'b1, 8'h40, 1'b0);
    cycle(1'b1, 1'b0, 8'h51, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 1'b0, 8'h52, 1'b0, 8'h00, 1'b0);
    check("rst2_pend_busy", 32'(bus.cpu_busy_o), 32'h1);
    cycle(1'b1, 1'b0, 8'h53, 1'b0, 8'h00, 1'b1);
    @(posedge clk); #1;
    rst             = 1'b0;
    bus.pix_valid_i = 1'b0;
    bus.pix_blank_i = 1'b0;
    bus.cpu_req_i   = 1'b0;
    #1;
    check("rst2_valid", 32'(bus.rgb_valid_o), 32'h0);
    check("rst2_busy",  32'(bus.cpu_busy_o), 32'h0);
    check("rst2_ack",   32'(bus.cpu_ack_o), 32'h0);
    check("rst2_data",  32'(bus.cpu_data_o), 32'h0);
    exp_q.delete();
    last_blank = 1'b0;
    last_rgb   = '0;
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("rst2_flush_valid", 32'(bus.rgb_valid_o), 32'h0);
      if (bus.cpu_ack_o) ack_cnt++;
    end
    check("rst2_no_ack", 32'(ack_cnt), 32'd0);

    // Post-reset request completes normally.
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0);
    idle(1);
    check("post_busy", 32'(bus.cpu_busy_o), 32'h1);
    idle(2);
    check("post_ack",  32'(bus.cpu_ack_o), 32'h1);
    check("post_data", 32'(bus.cpu_data_o), 32'hF123);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
